sync_fifo: RTL and testbench

- Single-clock, show-ahead (first-word-fall-through) FIFO.
- Buffers received UART bytes between the RX deserializer, which pushes, and the bus read port, which pops.
- The head entry is visible on dout combinationally whenever the FIFO is not empty.
- Depth is arbitrary and need not be a power of two; the default configuration is 255 x 8.

---
 rtl/sync_fifo_pkg.sv | 7 +
 rtl/sync_fifo_if.sv | 40 ++++
 rtl/sync_fifo.sv | 98 +++++++++
 tb/tb_sync_fifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared FIFO defaults for the UART receive buffer.
package sync_fifo_pkg;

    localparam int FIFO_DEFAULT_WIDTH = 8;
    localparam int FIFO_DEFAULT_DEPTH = 255;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_if.sv
// Push/pop/status bundle for sync_fifo. The level signal (and the DEPTH
// parameter that sizes it) exists only when SYNC_FIFO_LEVEL_EN is defined.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEFAULT_WIDTH
`ifdef SYNC_FIFO_LEVEL_EN
    ,
    parameter int DEPTH = FIFO_DEFAULT_DEPTH
`endif
);

    logic [DATA_WIDTH-1:0] din;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
`ifdef SYNC_FIFO_LEVEL_EN
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic [CNT_W-1:0]      level;
`endif

    modport master (
        output din, push, pop,
`ifdef SYNC_FIFO_LEVEL_EN
        input  level,
`endif
        input  dout, full, empty
    );

    modport slave (
        input  din, push, pop,
`ifdef SYNC_FIFO_LEVEL_EN
        output level,
`endif
        output dout, full, empty
    );

endinterface : sync_fifo_if

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO of arbitrary depth (default 255 x 8).
// Define SYNC_FIFO_LEVEL_EN to expose the occupancy count on bus.level.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEFAULT_WIDTH,
    parameter int DEPTH      = FIFO_DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        resetn,
    sync_fifo_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_r;
    logic [ADDR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  full_r;
    logic                  empty_r;

    logic                  do_push_s;
    logic                  do_pop_s;
    logic [ADDR_W-1:0]     wr_ptr_nxt_s;
    logic [ADDR_W-1:0]     rd_ptr_nxt_s;
    logic [CNT_W-1:0]      count_nxt_s;

    assign do_push_s = bus.push & ~full_r;
    assign do_pop_s  = bus.pop & ~empty_r;

    // Pointer advance; the explicit wrap at DEPTH-1 keeps non-power-of-2 depths correct.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (do_push_s) begin
            if (wr_ptr_r == ADDR_W'(DEPTH - 1)) begin
                wr_ptr_nxt_s = '0;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r + ADDR_W'(1);
            end
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (do_pop_s) begin
            if (rd_ptr_r == ADDR_W'(DEPTH - 1)) begin
                rd_ptr_nxt_s = '0;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r + ADDR_W'(1);
            end
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Occupancy next-state: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage write; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (resetn && do_push_s) begin
            mem_r[wr_ptr_r] <= bus.din;
        end
    end

    // Pointers, count and flags; flags come from the next count so they match the post-edge state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == CNT_W'(DEPTH));
            empty_r  <= (count_nxt_s == CNT_W'(0));
        end
    end

    assign bus.dout  = mem_r[rd_ptr_r];
    assign bus.full  = full_r;
    assign bus.empty = empty_r;
`ifdef SYNC_FIFO_LEVEL_EN
    assign bus.level = count_r;
`endif

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: directed scenarios plus random traffic,
// checked against a queue-based reference FIFO.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 255;

    logic clk;
    logic resetn;

`ifdef SYNC_FIFO_LEVEL_EN
    sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
`else
    sync_fifo_if #(.DATA_WIDTH(DW)) bus ();
`endif

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] model_q[$];   // reference FIFO contents (state after last edge)
    logic [DW-1:0] exp_q[$];     // words the consumer is expected to pop, in order
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: flags and show-ahead head every cycle; popped words against the scoreboard.
    always @(negedge clk) begin
        if (chk_en) begin
            check("empty_flag", int'(bus.empty), int'(model_q.size() == 0));
            check("full_flag", int'(bus.full), int'(model_q.size() == DEPTH));
`ifdef SYNC_FIFO_LEVEL_EN
            check("level", int'(bus.level), model_q.size());
`endif
            if (model_q.size() > 0) begin
                check("head_dout", int'(bus.dout), int'(model_q[0]));
            end
            if (bus.pop && !bus.empty) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    check("pop_data", int'(bus.dout), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic step(input bit p, input bit q, input logic [DW-1:0] d);
        bit acc_push;
        bit acc_pop;
        bus.push = p;
        bus.pop  = q;
        bus.din  = d;
        acc_push = p && (model_q.size() < DEPTH);
        acc_pop  = q && (model_q.size() > 0);
        if (acc_pop) exp_q.push_back(model_q[0]);
        @(posedge clk);
        if (acc_pop) void'(model_q.pop_front());
        if (acc_push) model_q.push_back(d);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    task automatic do_reset(input int n, input bit push_during);
        chk_en   = 1'b0;
        resetn   = 1'b0;
        bus.push = push_during;
        bus.pop  = push_during;
        bus.din  = 8'hEE;
        repeat (n) @(posedge clk);
        #1;
        resetn   = 1'b1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        model_q.delete();
        exp_q.delete();
        @(negedge clk);
        check("reset_empty", int'(bus.empty), 1);
        check("reset_full", int'(bus.full), 0);
`ifdef SYNC_FIFO_LEVEL_EN
        check("reset_level", int'(bus.level), 0);
`endif
        chk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.din  = 8'h00;
        resetn   = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2, 1'b0);

        // Pops on an empty FIFO are ignored; later traffic is intact.
        repeat (3) step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h99);
        step(1'b0, 1'b1, 8'h00);

        // Show-ahead ordering with an idle cycle before popping.
        step(1'b1, 1'b0, 8'h41);
        step(1'b1, 1'b0, 8'h42);
        step(1'b1, 1'b0, 8'h43);
        step(1'b0, 1'b0, 8'h00);
        check("showahead_0x41", int'(bus.dout), 32'h41);
        repeat (3) step(1'b0, 1'b1, 8'h00);
        check("showahead_empty", int'(bus.empty), 1);

        // Fill to full, overflow push dropped, drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
        check("fill_full", int'(bus.full), 1);
        step(1'b1, 1'b0, 8'hFF);
        check("overflow_ignored_full", int'(bus.full), 1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
        check("drain_empty", int'(bus.empty), 1);

        // Wrap-around through the non-power-of-2 boundary.
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0, DW'(i * 7));
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, DW'(8'h10 + i));
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 8'h00);

        // Simultaneous push and pop: empty, mid-level, full.
        step(1'b1, 1'b1, 8'h55);
        check("simul_empty_not_empty", int'(bus.empty), 0);
        check("simul_empty_dout", int'(bus.dout), 32'h55);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(8'h60 + i));
        step(1'b1, 1'b1, 8'h70);
        check("simul_mid_level", model_q.size(), 5);
        for (int i = 0; i < DEPTH - 5; i++) step(1'b1, 1'b0, DW'(i));
        check("simul_full_before", int'(bus.full), 1);
        step(1'b1, 1'b1, 8'hDD);
        check("simul_full_drops", int'(bus.full), 0);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 8'h00);

        // Reset in the middle of traffic, with push/pop held high.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'(8'h30 + i));
        do_reset(1, 1'b1);
        step(1'b1, 1'b0, 8'hA5);
        check("post_reset_dout", int'(bus.dout), 32'hA5);
        step(1'b0, 1'b1, 8'h00);

        // Random traffic with phases biased toward filling and draining.
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 400; i++) begin
                int pp;
                pp = (ph % 2 == 0) ? 75 : 30;
                step(($urandom_range(99) < pp), ($urandom_range(99) < 100 - pp),
                     DW'($urandom));
            end
        end
        while (model_q.size() > 0) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        check("scoreboard_drained", exp_q.size(), 0);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo
